// File: rtl/relu_act_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : relu_act_sched_pkg
//  Purpose  : Shared fixed-point constants, clamp-limit helper and the
//             layer FSM state encoding for the ReLU6 activation scheduler.
//  Contents : FXP_FRAC_DEFAULT, FINAL_SHIFT_DEFAULT, THRESHOLD_DEFAULT,
//             clamp_limit(), fsm_state_e
//  Revision : 1.0  initial release
// ============================================================================
package relu_act_sched_pkg;

  // Accumulator fixed-point format and requantisation defaults.
  localparam int FXP_FRAC_DEFAULT    = 15;
  localparam int FINAL_SHIFT_DEFAULT = 8;
  localparam int THRESHOLD_DEFAULT   = 6;

  // Upper clamp expressed in accumulator units: THRESHOLD scaled into the
  // fixed-point domain.
  function automatic longint clamp_limit(input int threshold, input int frac);
    return longint'(threshold) <<< frac;
  endfunction

  // Layer-level sequencing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/relu_act_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : relu_act_sched_if
//  Purpose  : Lane request bus plus activation output stream of the ReLU6
//             activation scheduler.
//  Signals  : lane_valid/lane_data/lane_ready - per-lane accumulator requests
//             out_valid/out_ready/out_data/out_lane - activation stream
//  Modports : master - the scheduler (accepts lanes, sources activations)
//             slave  - the surroundings (drives lanes, sinks activations)
//  Revision : 1.0  initial release
// ============================================================================
interface relu_act_sched_if #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 32,
  parameter int OUT_W     = 16
);
  import relu_act_sched_pkg::*;

  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]       lane_valid;
  logic [NUM_LANES*WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0]       lane_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [LANE_W-1:0]          out_lane;

  modport master (
    input  lane_valid,
    input  lane_data,
    output lane_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_lane
  );

  modport slave (
    output lane_valid,
    output lane_data,
    input  lane_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_lane
  );

endinterface
`default_nettype wire

// File: rtl/relu_act_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Grants the first requesting
//             lane at or above ptr, wrapping past the top lane.
//  Ports    : req       in  NUM_LANES  request vector
//             ptr       in  LANE_W     highest-priority lane this cycle
//             enable    in  1          grant permitted
//             grant     out NUM_LANES  one-hot grant (all zero if none)
//             grant_idx out LANE_W     encoded index of the granted lane
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import relu_act_sched_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] ptr,
  input  logic                         enable,
  output logic [NUM_LANES-1:0]         grant,
  output logic [$clog2(NUM_LANES)-1:0] grant_idx
);

  localparam int LANE_W = $clog2(NUM_LANES);

  int   idx;
  logic found;

  // Walk the lanes starting at ptr; the first requester wins. The wrap is an
  // explicit subtract so non-power-of-two lane counts work too.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_LANES) begin
        idx = idx - NUM_LANES;
      end
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = LANE_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/relu_act_sched.sv
`default_nettype none
// ============================================================================
//  Module   : relu_act_sched
//  Purpose  : Shares one ReLU6 clamp/requantise datapath between NUM_LANES
//             accumulator lanes. Round-robin grant, one item per cycle, into
//             a registered valid/ready output stage. A layer FSM accepts
//             cfg_count items, drains the output register and pulses done.
//  Ports    : clk, rst_n (sync, active-low)
//             start/cfg_count - layer launch and item count
//             busy/done       - layer status, done is a one-cycle pulse
//             clip_hi_cnt/clip_lo_cnt - saturating clamp statistics
//             bus (master)    - lane requests and activation output stream
//  Revision : 1.0  initial release
// ============================================================================
module relu_act_sched
  import relu_act_sched_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int WIDTH       = 32,
  parameter int OUT_W       = 16,
  parameter int THRESHOLD   = THRESHOLD_DEFAULT,
  parameter int FXP_FRAC    = FXP_FRAC_DEFAULT,
  parameter int FINAL_SHIFT = FINAL_SHIFT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] clip_hi_cnt,
  output logic [CNT_W-1:0] clip_lo_cnt,
  relu_act_sched_if.master bus
);

  localparam int LANE_W = $clog2(NUM_LANES);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic signed [WIDTH-1:0] T_LIM = WIDTH'(clamp_limit(THRESHOLD, FXP_FRAC));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [CNT_W-1:0]  acc_q,       acc_d;
  logic [LANE_W-1:0] ptr_q,       ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q,  out_data_d;
  logic [LANE_W-1:0] out_lane_q,  out_lane_d;
  logic [CNT_W-1:0]  clip_hi_q,   clip_hi_d;
  logic [CNT_W-1:0]  clip_lo_q,   clip_lo_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic                    w_adv;
  logic                    w_grant_en;
  logic [NUM_LANES-1:0]    w_grant;
  logic [LANE_W-1:0]       w_grant_idx;
  logic                    w_any_grant;

  // The output register can take a new item when empty or being drained.
  assign w_adv      = !out_valid_q || bus.out_ready;
  assign w_grant_en = (state_q == ST_RUN) && w_adv && (acc_q < count_q);

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .req       (bus.lane_valid),
    .ptr       (ptr_q),
    .enable    (w_grant_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any_grant    = |w_grant;
  assign bus.lane_ready = w_grant;

  // --------------------------------------------------------------------------
  // Clamp / requantise on the granted lane
  // --------------------------------------------------------------------------
  logic signed [WIDTH-1:0] w_lane_acc;
  logic signed [WIDTH-1:0] w_clamped;
  logic signed [WIDTH-1:0] w_shifted;
  logic                    w_clip_lo;
  logic                    w_clip_hi;

  assign w_lane_acc = $signed(bus.lane_data[int'(w_grant_idx)*WIDTH +: WIDTH]);

  always_comb begin
    w_clip_lo = 1'b0;
    w_clip_hi = 1'b0;
    w_clamped = w_lane_acc;
    if (w_lane_acc[WIDTH-1]) begin
      w_clip_lo = 1'b1;
      w_clamped = '0;
    end else if (w_lane_acc > T_LIM) begin
      w_clip_hi = 1'b1;
      w_clamped = T_LIM;
    end
  end

  assign w_shifted = w_clamped >>> FINAL_SHIFT;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    clip_hi_d   = clip_hi_q;
    clip_lo_d   = clip_lo_q;

    // Output stage: load on grant, empty when it advances with nothing new,
    // otherwise hold (this is what keeps data stable under back-pressure).
    if (w_any_grant) begin
      out_valid_d = 1'b1;
      out_data_d  = OUT_W'(w_shifted);
      out_lane_d  = w_grant_idx;
      ptr_d       = (w_grant_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                            : w_grant_idx + LANE_W'(1);
      acc_d       = acc_q + CNT_W'(1);
      if (w_clip_hi && (clip_hi_q != '1)) begin
        clip_hi_d = clip_hi_q + CNT_W'(1);
      end
      if (w_clip_lo && (clip_lo_q != '1)) begin
        clip_lo_d = clip_lo_q + CNT_W'(1);
      end
    end else if (w_adv) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d   = cfg_count;
          acc_d     = '0;
          clip_hi_d = '0;
          clip_lo_d = '0;
          state_d   = (cfg_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Leave on the grant that takes the accepted count to its target.
        if (w_any_grant && (acc_d == count_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || bus.out_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      clip_hi_q   <= '0;
      clip_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      clip_hi_q   <= clip_hi_d;
      clip_lo_q   <= clip_lo_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign clip_hi_cnt   = clip_hi_q;
  assign clip_lo_cnt   = clip_lo_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lane  = out_lane_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_act_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_act_sched
//  Purpose  : Self-checking bench for relu_act_sched. A behavioural model
//             (integer arithmetic, queues) predicts grants, activations,
//             status and clip counts every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_act_sched;

  localparam int     NL     = 4;
  localparam int     W      = 32;
  localparam int     OW     = 16;
  localparam int     CW     = 16;
  localparam longint T_LIM  = 6 * 32768;   // 6 << 15
  localparam int     FSHIFT = 8;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk;
  logic rst_n;
  logic start;
  logic [CW-1:0] cfg_count;
  logic busy;
  logic done;
  logic [CW-1:0] clip_hi_cnt;
  logic [CW-1:0] clip_lo_cnt;

  logic [NL-1:0]   lane_valid;
  logic [NL*W-1:0] lane_data;
  logic            out_ready;

  relu_act_sched_if #(.NUM_LANES(NL), .WIDTH(W), .OUT_W(OW)) bus_if ();

  assign bus_if.lane_valid = lane_valid;
  assign bus_if.lane_data  = lane_data;
  assign bus_if.out_ready  = out_ready;

  relu_act_sched #(
    .NUM_LANES (NL),
    .WIDTH     (W),
    .OUT_W     (OW),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_count   (cfg_count),
    .busy        (busy),
    .done        (done),
    .clip_hi_cnt (clip_hi_cnt),
    .clip_lo_cnt (clip_lo_cnt),
    .bus         (bus_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counters
  int n_pass  = 0;
  int n_total = 0;

  // Model state
  int  m_phase, m_ptr, m_acc, m_count, m_hi, m_lo;
  bit  m_pending;
  int  exp_data[$];
  int  exp_lane[$];
  bit  m_done_seen;

  // Observation logs (taken from the DUT pins)
  int          cyc;
  int          dut_grants[$];
  int          obs_data[$];
  int          n_out_obs;
  int          last_grant_cyc;
  int          done_cyc;
  logic [NL-1:0] rdy_or;

  // Per-layer drive controls
  int vmode;   // 0 all valid, 1 lane 2 only, 2 random mask
  int rmode;   // 0 always ready, 1 random, 2 stall cycles 2..4
  bit fixed_data;
  int fixed_vals[NL] = '{-5, 100000, 300000, 196608};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] rnd_acc();
    case ($urandom_range(0, 4))
      0:       return W'(-longint'($urandom_range(1, 1000000)));
      1:       return W'($urandom_range(0, 196608));
      2:       return W'($urandom_range(196609, 3000000));
      3:       return W'(196608);
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_ptr     = 0;
    m_acc     = 0;
    m_count   = 0;
    m_hi      = 0;
    m_lo      = 0;
    m_pending = 0;
    exp_data.delete();
    exp_lane.delete();
  endtask

  task automatic drive(input int c);
    for (int l = 0; l < NL; l++) begin
      case (vmode)
        0:       lane_valid[l] = 1'b1;
        1:       lane_valid[l] = (l == 2);
        default: lane_valid[l] = 1'($urandom_range(0, 1));
      endcase
      lane_data[l*W +: W] = fixed_data ? W'(fixed_vals[l]) : rnd_acc();
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = !(c >= 2 && c <= 4);
    endcase
  endtask

  // One clock cycle: check the DUT against the model, observe, then advance
  // the model by the rules and let the clock edge pass.
  task automatic tick();
    int            g;
    logic [NL-1:0] exp_rdy;
    bit            en, old_pending;
    longint        v, r;
    #1;
    en = (m_phase == P_RUN) && (!m_pending || out_ready) && (m_acc < m_count);
    g  = -1;
    if (en) begin
      for (int k = 0; k < NL; k++) begin
        if (g < 0 && lane_valid[(m_ptr + k) % NL]) g = (m_ptr + k) % NL;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    chk("lane_ready", 64'(bus_if.lane_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus_if.out_valid), 64'(m_pending));
    chk("busy", 64'(busy), 64'(m_phase == P_RUN || m_phase == P_DRAIN));
    chk("done", 64'(done), 64'(m_phase == P_DONE));
    chk("clip_hi_cnt", 64'(clip_hi_cnt), 64'(m_hi));
    chk("clip_lo_cnt", 64'(clip_lo_cnt), 64'(m_lo));
    if (m_pending) begin
      chk("out_data", 64'(bus_if.out_data), 64'(exp_data[0]));
      chk("out_lane", 64'(bus_if.out_lane), 64'(exp_lane[0]));
    end

    // Observations from the DUT pins
    rdy_or = rdy_or | bus_if.lane_ready;
    for (int k = 0; k < NL; k++) begin
      if (bus_if.lane_ready[k] === 1'b1) begin
        dut_grants.push_back(k);
        last_grant_cyc = cyc;
      end
    end
    if (bus_if.out_valid === 1'b1 && out_ready) begin
      obs_data.push_back(int'(bus_if.out_data));
      n_out_obs++;
    end
    if (done === 1'b1) done_cyc = cyc;
    if (m_phase == P_DONE) m_done_seen = 1;

    // Model advance
    old_pending = m_pending;
    if (m_pending && out_ready) begin
      void'(exp_data.pop_front());
      void'(exp_lane.pop_front());
    end
    if (g >= 0) begin
      v = longint'($signed(lane_data[g*W +: W]));
      if (v < 0) begin
        r = 0;
        if (m_lo < 65535) m_lo++;
      end else if (v > T_LIM) begin
        r = T_LIM;
        if (m_hi < 65535) m_hi++;
      end else begin
        r = v;
      end
      exp_data.push_back(int'((r >> FSHIFT) & 64'hFFFF));
      exp_lane.push_back(g);
      m_pending = 1;
      m_ptr     = (g + 1) % NL;
      m_acc++;
    end else if (!m_pending || out_ready) begin
      m_pending = 0;
    end
    case (m_phase)
      P_IDLE: if (start) begin
        m_count = int'(cfg_count);
        m_acc   = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_phase = (cfg_count == 0) ? P_DONE : P_RUN;
      end
      P_RUN:   if (m_acc == m_count) m_phase = P_DRAIN;
      P_DRAIN: if (!old_pending || out_ready) m_phase = P_DONE;
      default: m_phase = P_IDLE;
    endcase
    if (!rst_n) model_reset();

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    dut_grants.delete();
    obs_data.delete();
    n_out_obs      = 0;
    last_grant_cyc = -100;
    done_cyc       = -1;
    rdy_or         = '0;
    m_done_seen    = 0;
  endtask

  // Launch a layer and run it until the model has passed through DONE.
  // If inject is set, a second start (count 2) is pulsed two cycles in.
  task automatic run_layer(input int cnt, input bit inject);
    int c;
    clear_logs();
    drive(0);
    start     = 1'b1;
    cfg_count = CW'(cnt);
    tick();
    start = 1'b0;
    c = 0;
    while (!(m_done_seen && m_phase == P_IDLE) && c < 500) begin
      drive(c);
      if (inject && c == 2) begin
        start     = 1'b1;
        cfg_count = CW'(2);
      end
      tick();
      start = 1'b0;
      c++;
    end
    chk("layer_completes", 64'(m_done_seen), 64'(1));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_count  = '0;
    lane_valid = '0;
    lane_data  = '0;
    out_ready  = 1'b1;
    vmode      = 0;
    rmode      = 0;
    fixed_data = 0;
    cyc        = 0;
    clear_logs();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus_if.out_data), 64'(0));
    chk("rst_lane_ready", 64'(bus_if.lane_ready), 64'(0));
    chk("rst_clip_hi", 64'(clip_hi_cnt), 64'(0));
    rst_n = 1'b1;
    tick();

    // Fixed data, four lanes, full throughput
    vmode = 0; rmode = 0; fixed_data = 1;
    run_layer(4, 0);
    chk("t1_ngrants", 64'(dut_grants.size()), 64'(4));
    for (int i = 0; i < 4 && i < dut_grants.size(); i++) chk("t1_grant", 64'(dut_grants[i]), 64'(i));
    chk("t1_nout", 64'(obs_data.size()), 64'(4));
    if (obs_data.size() == 4) begin
      chk("t1_out0", 64'(obs_data[0]), 64'(0));
      chk("t1_out1", 64'(obs_data[1]), 64'(390));
      chk("t1_out2", 64'(obs_data[2]), 64'(768));
      chk("t1_out3", 64'(obs_data[3]), 64'(768));
    end
    chk("t1_clip_lo", 64'(clip_lo_cnt), 64'(1));
    chk("t1_clip_hi", 64'(clip_hi_cnt), 64'(1));
    chk("t1_done_latency", 64'(done_cyc - last_grant_cyc), 64'(2));
    fixed_data = 0;

    // Six items, all lanes valid: wraps once, leaves ptr at 2
    run_layer(6, 0);
    chk("t2_ngrants", 64'(dut_grants.size()), 64'(6));
    for (int i = 0; i < 6 && i < dut_grants.size(); i++) chk("t2_grant", 64'(dut_grants[i]), 64'(i % 4));

    // Back-pressure for three cycles mid-stream; next layer starts at lane 2
    rmode = 2;
    run_layer(8, 0);
    chk("t3_first_grant", 64'(dut_grants.size() > 0 ? dut_grants[0] : -1), 64'(2));
    chk("t3_nout", 64'(n_out_obs), 64'(8));
    chk("t3_ngrants", 64'(dut_grants.size()), 64'(8));
    rmode = 0;

    // Single requesting lane
    vmode = 1;
    run_layer(3, 0);
    chk("t4_ngrants", 64'(dut_grants.size()), 64'(3));
    chk("t4_other_lanes", 64'(rdy_or & 4'b1011), 64'(0));
    vmode = 0;

    // Empty layer, then start ignored while running
    run_layer(0, 0);
    chk("t5_zero_grants", 64'(dut_grants.size()), 64'(0));
    run_layer(5, 1);
    chk("t5_ignored_start", 64'(n_out_obs), 64'(5));

    // Reset in the middle of a layer with the output register full
    clear_logs();
    drive(0);
    start = 1'b1; cfg_count = CW'(10);
    tick();
    start = 1'b0;
    repeat (3) begin drive(0); tick(); end
    chk("t6_pre_out_valid", 64'(bus_if.out_valid), 64'(1));
    rst_n = 1'b0;
    drive(0);
    tick();
    rst_n = 1'b1;
    chk("t6_out_valid", 64'(bus_if.out_valid), 64'(0));
    chk("t6_out_data", 64'(bus_if.out_data), 64'(0));
    chk("t6_out_lane", 64'(bus_if.out_lane), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_clip_hi", 64'(clip_hi_cnt), 64'(0));
    chk("t6_clip_lo", 64'(clip_lo_cnt), 64'(0));
    clear_logs();
    repeat (5) begin drive(0); tick(); end
    chk("t6_no_done", 64'(done_cyc), 64'(-1));
    chk("t6_no_grant_idle", 64'(dut_grants.size()), 64'(0));
    run_layer(2, 0);
    chk("t6_ptr_reset", 64'(dut_grants.size() > 0 ? dut_grants[0] : -1), 64'(0));

    // Randomised layers
    vmode = 2; rmode = 1;
    for (int n = 0; n < 6; n++) begin
      run_layer($urandom_range(1, 20), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
